// File: rtl/axi4lite_write_issuer_if.sv
// ---------------------------------------------------------------------------
// axi4lite_write_issuer_if
//   Bundles the bus-side signals of the AXI4 -> AXI4-Lite write issuer.
//   Groups:
//     cmd_*    : per-beat address packet from the AW conversion FIFO
//     wr_*     : AXI4 W beats
//     m_aw_*   : AXI4-Lite AW channel (issuer is master)
//     m_w_*    : AXI4-Lite W channel
//     m_b_*    : AXI4-Lite B channel
//     s_b_*    : merged AXI4 B response back to the AXI4 master
//     last_err : sticky cmd_last / wr_last disagreement flag
//   Modports:
//     master : the issuer itself
//     slave  : the surrounding environment (FIFO, W source, Lite slave, B sink)
// ---------------------------------------------------------------------------
interface axi4lite_write_issuer_if #(
  parameter int axi4_id_size   = 5,
  parameter int axi4_addr_size = 32,
  parameter int axi4_data_size = 64
);
  localparam int STRB_W = axi4_data_size / 8;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [axi4_addr_size-1:0] cmd_addr;
  logic [axi4_id_size-1:0]   cmd_id;
  logic [2:0]                cmd_prot;
  logic                      cmd_last;

  logic                      wr_valid;
  logic                      wr_ready;
  logic [axi4_data_size-1:0] wr_data;
  logic [STRB_W-1:0]         wr_strb;
  logic                      wr_last;

  logic                      m_aw_valid;
  logic                      m_aw_ready;
  logic [axi4_addr_size-1:0] m_aw_addr;
  logic [2:0]                m_aw_prot;

  logic                      m_w_valid;
  logic                      m_w_ready;
  logic [axi4_data_size-1:0] m_w_data;
  logic [STRB_W-1:0]         m_w_strb;

  logic                      m_b_valid;
  logic                      m_b_ready;
  logic [1:0]                m_b_resp;

  logic                      s_b_valid;
  logic                      s_b_ready;
  logic [axi4_id_size-1:0]   s_b_id;
  logic [1:0]                s_b_resp;

  logic                      last_err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_id, cmd_prot, cmd_last,
    output cmd_ready,
    input  wr_valid, wr_data, wr_strb, wr_last,
    output wr_ready,
    output m_aw_valid, m_aw_addr, m_aw_prot,
    input  m_aw_ready,
    output m_w_valid, m_w_data, m_w_strb,
    input  m_w_ready,
    input  m_b_valid, m_b_resp,
    output m_b_ready,
    output s_b_valid, s_b_id, s_b_resp,
    input  s_b_ready,
    output last_err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_id, cmd_prot, cmd_last,
    input  cmd_ready,
    output wr_valid, wr_data, wr_strb, wr_last,
    input  wr_ready,
    input  m_aw_valid, m_aw_addr, m_aw_prot,
    output m_aw_ready,
    input  m_w_valid, m_w_data, m_w_strb,
    output m_w_ready,
    output m_b_valid, m_b_resp,
    input  m_b_ready,
    input  s_b_valid, s_b_id, s_b_resp,
    output s_b_ready,
    input  last_err
  );
endinterface

// File: rtl/axi4lite_write_issuer.sv
// ---------------------------------------------------------------------------
// axi4lite_write_issuer
//   Write-path back end of the AXI4 -> AXI4-Lite bridge. For every beat it
//   pairs one address packet with one AXI4 W beat, issues a single AXI4-Lite
//   AW + W transfer, collects the Lite B response and folds it into a burst
//   accumulator. After the beat flagged cmd_last it returns one merged AXI4 B
//   response carrying the burst ID.
//   Ports:
//     clk  : clock
//     rstn : synchronous active-low reset
//     bus  : axi4lite_write_issuer_if.master (cmd, wr, m_aw, m_w, m_b, s_b,
//            last_err)
//   All outputs come straight from registers or are decoded from the state
//   register and flag registers; no input reaches a valid/ready output
//   combinationally.
// ---------------------------------------------------------------------------
module axi4lite_write_issuer #(
  parameter int axi4_id_size   = 5,
  parameter int axi4_addr_size = 32,
  parameter int axi4_data_size = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  axi4lite_write_issuer_if.master bus
);
  localparam int STRB_W = axi4_data_size / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT_B = 2'd2,
    S_SEND_B = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Held / done flags and run qualifier
  logic r_run;
  logic r_cmd_held;
  logic r_w_held;
  logic r_aw_done;
  logic r_w_done;
  logic r_last_err;

  // Latched beat payload
  logic [axi4_addr_size-1:0] r_addr;
  logic [2:0]                r_prot;
  logic [axi4_id_size-1:0]   r_id;
  logic                      r_cmd_last;
  logic [axi4_data_size-1:0] r_data;
  logic [STRB_W-1:0]         r_strb;
  logic                      r_wr_last;
  logic [1:0]                r_resp_acc;

  // Decoded outputs
  logic                      w_cmd_ready;
  logic                      w_wr_ready;
  logic                      w_m_aw_valid;
  logic                      w_m_w_valid;
  logic                      w_m_b_ready;
  logic                      w_s_b_valid;
  logic [axi4_id_size-1:0]   w_s_b_id;
  logic [1:0]                w_s_b_resp;

  // Handshakes and derived terms
  logic w_cmd_hs;
  logic w_wr_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_sb_hs;
  logic w_cmd_have;
  logic w_w_have;
  logic w_cmd_last_eff;
  logic w_wr_last_eff;

  // Merge a Lite response into the burst accumulator. EXOKAY folds to OKAY;
  // with the remaining codes 0/2/3 the priority order equals numeric order.
  function automatic logic [1:0] resp_merge(input logic [1:0] acc, input logic [1:0] resp);
    logic [1:0] norm;
    norm = (resp == 2'b01) ? 2'b00 : resp;
    resp_merge = (norm > acc) ? norm : acc;
  endfunction

  assign w_cmd_hs   = bus.cmd_valid & w_cmd_ready;
  assign w_wr_hs    = bus.wr_valid & w_wr_ready;
  assign w_aw_hs    = w_m_aw_valid & bus.m_aw_ready;
  assign w_w_hs     = w_m_w_valid & bus.m_w_ready;
  assign w_b_hs     = w_m_b_ready & bus.m_b_valid;
  assign w_sb_hs    = w_s_b_valid & bus.s_b_ready;
  assign w_cmd_have = r_cmd_held | w_cmd_hs;
  assign w_w_have   = r_w_held | w_wr_hs;

  // Last flags as they will be latched when ISSUE is entered; a packet
  // accepted in the same cycle has not reached its register yet.
  assign w_cmd_last_eff = w_cmd_hs ? bus.cmd_last : r_cmd_last;
  assign w_wr_last_eff  = w_wr_hs ? bus.wr_last : r_wr_last;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_have && w_w_have) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_nxt = S_WAIT_B;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_WAIT_B: begin
        if (w_b_hs) begin
          w_state_nxt = r_cmd_last ? S_SEND_B : S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_B;
        end
      end
      S_SEND_B: begin
        if (w_sb_hs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_SEND_B;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from state and flag registers
  always_comb begin
    w_cmd_ready  = 1'b0;
    w_wr_ready   = 1'b0;
    w_m_aw_valid = 1'b0;
    w_m_w_valid  = 1'b0;
    w_m_b_ready  = 1'b0;
    w_s_b_valid  = 1'b0;
    w_s_b_id     = {axi4_id_size{1'b0}};
    w_s_b_resp   = 2'b00;
    case (r_state)
      S_IDLE: begin
        // r_run keeps the readies low while reset is applied
        w_cmd_ready = r_run & ~r_cmd_held;
        w_wr_ready  = r_run & ~r_w_held;
      end
      S_ISSUE: begin
        w_m_aw_valid = ~r_aw_done;
        w_m_w_valid  = ~r_w_done;
      end
      S_WAIT_B: begin
        w_m_b_ready = 1'b1;
      end
      S_SEND_B: begin
        w_s_b_valid = 1'b1;
        w_s_b_id    = r_id;
        w_s_b_resp  = r_resp_acc;
      end
      default: begin
        w_cmd_ready = 1'b0;
      end
    endcase
  end

  // Payload capture, handshake bookkeeping and response accumulation
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_run      <= 1'b0;
      r_cmd_held <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_last_err <= 1'b0;
      r_addr     <= {axi4_addr_size{1'b0}};
      r_prot     <= 3'b000;
      r_id       <= {axi4_id_size{1'b0}};
      r_cmd_last <= 1'b0;
      r_data     <= {axi4_data_size{1'b0}};
      r_strb     <= {STRB_W{1'b0}};
      r_wr_last  <= 1'b0;
      r_resp_acc <= 2'b00;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_hs) begin
            r_addr     <= bus.cmd_addr;
            r_prot     <= bus.cmd_prot;
            r_id       <= bus.cmd_id;
            r_cmd_last <= bus.cmd_last;
            r_cmd_held <= 1'b1;
          end
          if (w_wr_hs) begin
            r_data    <= bus.wr_data;
            r_strb    <= bus.wr_strb;
            r_wr_last <= bus.wr_last;
            r_w_held  <= 1'b1;
          end
          // Leaving for ISSUE: drop held flags (overrides the sets above)
          if (w_state_nxt == S_ISSUE) begin
            r_cmd_held <= 1'b0;
            r_w_held   <= 1'b0;
            if (w_cmd_last_eff != w_wr_last_eff) begin
              r_last_err <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_aw_hs) begin
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_w_done <= 1'b1;
          end
          if (w_state_nxt == S_WAIT_B) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_WAIT_B: begin
          if (w_b_hs) begin
            r_resp_acc <= resp_merge(r_resp_acc, bus.m_b_resp);
          end
        end
        S_SEND_B: begin
          if (w_sb_hs) begin
            r_resp_acc <= 2'b00;
          end
        end
        default: begin
          r_run <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.wr_ready   = w_wr_ready;
  assign bus.m_aw_valid = w_m_aw_valid;
  assign bus.m_aw_addr  = r_addr;
  assign bus.m_aw_prot  = r_prot;
  assign bus.m_w_valid  = w_m_w_valid;
  assign bus.m_w_data   = r_data;
  assign bus.m_w_strb   = r_strb;
  assign bus.m_b_ready  = w_m_b_ready;
  assign bus.s_b_valid  = w_s_b_valid;
  assign bus.s_b_id     = w_s_b_id;
  assign bus.s_b_resp   = w_s_b_resp;
  assign bus.last_err   = r_last_err;

endmodule

// File: tb/tb_axi4lite_write_issuer.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_write_issuer
//   Directed bench for axi4lite_write_issuer. Stimulus pushes expected Lite
//   AW/W transfers and merged B responses into queues; a monitor pops and
//   compares on every observed handshake. A responder process models the
//   AXI4-Lite slave and the AXI4 B sink with configurable stalls.
// ---------------------------------------------------------------------------
module tb_axi4lite_write_issuer;
  localparam int IDW = 5;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi4lite_write_issuer_if #(.axi4_id_size(IDW), .axi4_addr_size(AW), .axi4_data_size(DW)) bus ();

  axi4lite_write_issuer #(.axi4_id_size(IDW), .axi4_addr_size(AW), .axi4_data_size(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // expected-response queues
  logic [AW-1:0]  exp_aw_addr[$];
  logic [2:0]     exp_aw_prot[$];
  logic [DW-1:0]  exp_w_data[$];
  logic [SW-1:0]  exp_w_strb[$];
  logic [IDW-1:0] exp_b_id[$];
  logic [1:0]     exp_b_resp[$];
  logic [1:0]     bresp_q[$];

  // responder configuration
  int aw_delay = 0;
  int sb_stall = 0;

  // monitor statistics (written only by the monitor)
  int aw_hi = 0;
  int w_hi = 0;
  int sb_stall_seen = 0;
  int b_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  // Lite slave and AXI4 B sink model; acts on falling edges
  initial begin
    int aw_cnt = 0;
    int sb_cnt = 0;
    int w_pend = 0;
    bit b_fire = 1'b0;
    bus.m_aw_ready = 1'b1;
    bus.m_w_ready  = 1'b1;
    bus.m_b_valid  = 1'b0;
    bus.m_b_resp   = 2'b00;
    bus.s_b_ready  = 1'b1;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        bus.m_b_valid = 1'b0;
        w_pend = 0;
        b_fire = 1'b0;
        aw_cnt = 0;
        sb_cnt = 0;
      end else begin
        if (b_fire) begin
          bus.m_b_valid = 1'b0;
          b_fire = 1'b0;
        end
        if (bus.m_w_valid && bus.m_w_ready) w_pend++;
        if (!bus.m_b_valid && w_pend > 0 && bresp_q.size() > 0) begin
          bus.m_b_valid = 1'b1;
          bus.m_b_resp  = bresp_q.pop_front();
          w_pend--;
        end
        if (bus.m_b_valid && bus.m_b_ready) b_fire = 1'b1;
        if (!bus.m_aw_valid) begin
          aw_cnt = 0;
          bus.m_aw_ready = (aw_delay == 0);
        end else if (aw_cnt < aw_delay) begin
          aw_cnt++;
          bus.m_aw_ready = 1'b0;
        end else begin
          bus.m_aw_ready = 1'b1;
        end
        if (!bus.s_b_valid) begin
          sb_cnt = 0;
          bus.s_b_ready = (sb_stall == 0);
        end else if (sb_cnt < sb_stall) begin
          sb_cnt++;
          bus.s_b_ready = 1'b0;
        end else begin
          bus.s_b_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: samples just after the falling edge, after the responder
  initial begin
    bit aw_stall = 1'b0;
    bit w_stall = 1'b0;
    bit b_stall = 1'b0;
    logic [AW-1:0]  aw_prev;
    logic [DW-1:0]  w_prev;
    logic [IDW-1:0] bid_prev;
    logic [1:0]     bresp_prev;
    forever begin
      @(negedge clk);
      #1;
      if (!rstn) begin
        aw_stall = 1'b0;
        w_stall = 1'b0;
        b_stall = 1'b0;
      end else begin
        if (bus.m_aw_valid) aw_hi++;
        if (bus.m_w_valid) w_hi++;
        if (aw_stall) begin
          check("aw_valid_held", bus.m_aw_valid, 1'b1);
          check("aw_addr_stable", bus.m_aw_addr, aw_prev);
        end
        if (bus.m_aw_valid && bus.m_aw_ready) begin
          if (exp_aw_addr.size() == 0) fail_event("aw_unexpected");
          else begin
            check("aw_addr", bus.m_aw_addr, exp_aw_addr.pop_front());
            check("aw_prot", bus.m_aw_prot, exp_aw_prot.pop_front());
          end
        end
        aw_stall = bus.m_aw_valid && !bus.m_aw_ready;
        aw_prev  = bus.m_aw_addr;
        if (w_stall) check("w_data_stable", bus.m_w_data, w_prev);
        if (bus.m_w_valid && bus.m_w_ready) begin
          if (exp_w_data.size() == 0) fail_event("w_unexpected");
          else begin
            check("w_data", bus.m_w_data, exp_w_data.pop_front());
            check("w_strb", bus.m_w_strb, exp_w_strb.pop_front());
          end
        end
        w_stall = bus.m_w_valid && !bus.m_w_ready;
        w_prev  = bus.m_w_data;
        if (b_stall) begin
          check("s_b_valid_held", bus.s_b_valid, 1'b1);
          check("s_b_id_stable", bus.s_b_id, bid_prev);
          check("s_b_resp_stable", bus.s_b_resp, bresp_prev);
        end
        if (bus.s_b_valid) begin
          check("readies_low_in_send_b", {bus.cmd_ready, bus.wr_ready}, 2'b00);
          if (bus.s_b_ready) begin
            b_seen++;
            if (exp_b_id.size() == 0) fail_event("s_b_unexpected");
            else begin
              check("s_b_id", bus.s_b_id, exp_b_id.pop_front());
              check("s_b_resp", bus.s_b_resp, exp_b_resp.pop_front());
            end
          end else begin
            sb_stall_seen++;
          end
        end
        b_stall    = bus.s_b_valid && !bus.s_b_ready;
        bid_prev   = bus.s_b_id;
        bresp_prev = bus.s_b_resp;
      end
    end
  end

  int accept_cyc = 0;

  // Present one beat (cmd + W together) and wait until both are accepted
  task automatic send_beat(input logic [AW-1:0] addr, input logic [IDW-1:0] id, input logic [2:0] prot,
                           input logic clast, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                           input logic wlast, input logic [1:0] lite_resp, input logic [1:0] exp_merged);
    bit cd = 1'b0;
    bit wd = 1'b0;
    bit cf;
    bit wf;
    int n = 0;
    exp_aw_addr.push_back(addr);
    exp_aw_prot.push_back(prot);
    exp_w_data.push_back(data);
    exp_w_strb.push_back(strb);
    bresp_q.push_back(lite_resp);
    if (clast) begin
      exp_b_id.push_back(id);
      exp_b_resp.push_back(exp_merged);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_addr = addr; bus.cmd_id = id; bus.cmd_prot = prot; bus.cmd_last = clast;
    bus.wr_valid  = 1'b1; bus.wr_data = data; bus.wr_strb = strb; bus.wr_last = wlast;
    while (!(cd && wd) && n < 100) begin
      cf = bus.cmd_valid && bus.cmd_ready;
      wf = bus.wr_valid && bus.wr_ready;
      @(negedge clk);
      n++;
      if (cf) begin bus.cmd_valid = 1'b0; cd = 1'b1; end
      if (wf) begin bus.wr_valid = 1'b0; wd = 1'b1; end
    end
    accept_cyc = cyc;
    if (!(cd && wd)) begin
      fail_event("beat_accept_timeout");
      bus.cmd_valid = 1'b0;
      bus.wr_valid  = 1'b0;
    end
  endtask

  task automatic wait_b_done();
    int n = 0;
    while (exp_b_id.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_b_id.size() != 0) fail_event("s_b_timeout");
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {bus.cmd_ready, bus.wr_ready, bus.m_aw_valid, bus.m_w_valid, bus.m_b_ready,
                           bus.s_b_valid, bus.last_err, bus.s_b_resp, bus.s_b_id}, 64'd0);
    check({tag, "_aw_addr"}, bus.m_aw_addr, 64'd0);
    check({tag, "_aw_prot"}, bus.m_aw_prot, 64'd0);
    check({tag, "_w_data"}, bus.m_w_data, 64'd0);
    check({tag, "_w_strb"}, bus.m_w_strb, 64'd0);
  endtask

  initial begin
    int n;
    int snap_aw;
    int snap_w;
    int snap_sb;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_id = '0; bus.cmd_prot = 3'b000; bus.cmd_last = 1'b0;
    bus.wr_valid  = 1'b0; bus.wr_data = '0; bus.wr_strb = '0; bus.wr_last = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // single beat with latency measurement
    send_beat(32'h0000_1000, 5'd3, 3'b000, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'hFF, 1'b1, 2'b00, 2'b00);
    n = 0;
    while (!bus.s_b_valid && n < 50) begin @(negedge clk); n++; end
    // s_b_valid becomes visible after edge accept+2, so it is sampled on edge accept+3
    check("s_b_latency", cyc + 1 - accept_cyc, 3);
    wait_b_done();

    // 4-beat burst, SLVERR on beat 2
    send_beat(32'h0000_0100, 5'd5, 3'b010, 1'b0, 64'h1111_1111_1111_1111, 8'hFF, 1'b0, 2'b00, 2'b00);
    send_beat(32'h0000_0108, 5'd5, 3'b010, 1'b0, 64'h2222_2222_2222_2222, 8'h0F, 1'b0, 2'b10, 2'b00);
    send_beat(32'h0000_0110, 5'd5, 3'b010, 1'b0, 64'h3333_3333_3333_3333, 8'hF0, 1'b0, 2'b00, 2'b00);
    send_beat(32'h0000_0118, 5'd5, 3'b010, 1'b1, 64'h4444_4444_4444_4444, 8'h81, 1'b1, 2'b00, 2'b10);
    wait_b_done();

    // DECERR on beat 1, SLVERR on beat 3
    send_beat(32'h0000_2000, 5'd7, 3'b001, 1'b0, 64'hA5A5_0000_0000_0001, 8'hFF, 1'b0, 2'b11, 2'b00);
    send_beat(32'h0000_2008, 5'd7, 3'b001, 1'b0, 64'hA5A5_0000_0000_0002, 8'hFF, 1'b0, 2'b00, 2'b00);
    send_beat(32'h0000_2010, 5'd7, 3'b001, 1'b0, 64'hA5A5_0000_0000_0003, 8'hFF, 1'b0, 2'b10, 2'b00);
    send_beat(32'h0000_2018, 5'd7, 3'b001, 1'b1, 64'hA5A5_0000_0000_0004, 8'hFF, 1'b1, 2'b00, 2'b11);
    wait_b_done();
    // next burst starts from a clean accumulator; EXOKAY counts as OKAY
    send_beat(32'h0000_3000, 5'd9, 3'b000, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h3C, 1'b1, 2'b01, 2'b00);
    wait_b_done();

    // AW ready delayed 3 cycles, W ready high
    aw_delay = 3;
    snap_aw = aw_hi;
    snap_w = w_hi;
    send_beat(32'h0000_4000, 5'd11, 3'b100, 1'b1, 64'hCAFE_F00D_0000_4000, 8'hFF, 1'b1, 2'b00, 2'b00);
    wait_b_done();
    check("aw_valid_cycles", aw_hi - snap_aw, 4);
    check("w_valid_cycles", w_hi - snap_w, 1);
    aw_delay = 0;

    // s_b_ready held low for 5 cycles
    sb_stall = 5;
    snap_sb = sb_stall_seen;
    send_beat(32'h0000_5000, 5'd21, 3'b011, 1'b1, 64'h5555_AAAA_5555_AAAA, 8'hAA, 1'b1, 2'b10, 2'b10);
    wait_b_done();
    check("s_b_stall_cycles", sb_stall_seen - snap_sb, 5);
    sb_stall = 0;
    check("last_err_clear", bus.last_err, 1'b0);

    // reset while in ISSUE
    aw_delay = 20;
    send_beat(32'h0000_6000, 5'd13, 3'b111, 1'b1, 64'h6666_6666_6666_6666, 8'hFF, 1'b1, 2'b11, 2'b11);
    repeat (2) @(negedge clk);
    check("in_issue_before_reset", bus.m_aw_valid, 1'b1);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("mid_reset");
    exp_aw_addr.delete(); exp_aw_prot.delete();
    exp_w_data.delete(); exp_w_strb.delete();
    exp_b_id.delete(); exp_b_resp.delete();
    bresp_q.delete();
    aw_delay = 0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    send_beat(32'h0000_7000, 5'd17, 3'b000, 1'b1, 64'h7777_0000_7777_0000, 8'h0F, 1'b1, 2'b00, 2'b00);
    wait_b_done();

    // cmd_last=1 with wr_last=0: flag raised, B still returned
    send_beat(32'h0000_8000, 5'd30, 3'b000, 1'b1, 64'h8888_8888_8888_8888, 8'hFF, 1'b0, 2'b00, 2'b00);
    wait_b_done();
    check("last_err_set", bus.last_err, 1'b1);

    repeat (5) @(negedge clk);
    check("b_responses_total", b_seen, 8);
    check("aw_queue_drained", exp_aw_addr.size(), 0);
    check("w_queue_drained", exp_w_data.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
